// File: rtl/dl_rom_arbiter.sv
// dl_rom_arbiter: shares the ROM RAM port between the HPS download stream and CPU fetches,
// buffers one download byte and holds the game core in reset around a download.
module dl_rom_arbiter #(
  parameter int MEM_LAT   = 1,
  parameter int HOLD_CYC  = 16,
  parameter int ROM_SIZE  = 'h10000,
  parameter int CHR_BASE  = 'hC000,
  parameter int SPR_BASE  = 'hE000,
  parameter int PROM_BASE = 'hF000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        dl_wait,
  output logic        dl_overrun,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic [1:0]  mem_region,
  input  logic [7:0]  mem_dout,
  output logic        core_reset
);
  typedef enum logic [1:0] {IDLE, CPU_RD, DL_WR} state_t;
  state_t      state;
  logic [24:0] buf_addr;
  logic [7:0]  buf_data;
  logic [2:0]  lat_cnt;
  logic [7:0]  hold_cnt;
  logic [1:0]  region;
  always_comb
    region = buf_addr < 25'(CHR_BASE) ? 2'd0 :
             buf_addr < 25'(SPR_BASE) ? 2'd1 :
             buf_addr < 25'(PROM_BASE) ? 2'd2 : 2'd3;
  // dl_wait doubles as the buffer-full flag
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      state      <= IDLE;
      dl_wait    <= 1'b0;
      dl_overrun <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_data   <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'd0;
      mem_din    <= 8'd0;
      mem_region <= 2'd0;
      core_reset <= 1'b1;
      hold_cnt   <= 8'(HOLD_CYC);
      buf_addr   <= 25'd0;
      buf_data   <= 8'd0;
      lat_cnt    <= 3'd0;
    end else begin
      cpu_ack    <= 1'b0;
      mem_we     <= 1'b0;
      hold_cnt   <= ioctl_download ? 8'(HOLD_CYC) : hold_cnt - {7'd0, hold_cnt != 8'd0};
      core_reset <= ioctl_download || hold_cnt > 8'd1;
      if (ioctl_wr && dl_wait)
        dl_overrun <= 1'b1;
      if (ioctl_wr && !dl_wait) begin
        dl_wait  <= 1'b1;
        buf_addr <= ioctl_addr;
        buf_data <= ioctl_dout;
      end
      case (state)
        IDLE:
          if (dl_wait)
            state <= DL_WR;
          else if (cpu_req && !ioctl_download) begin
            state    <= CPU_RD;
            mem_addr <= cpu_addr;
            lat_cnt  <= 3'd0;
          end
        CPU_RD:
          if (lat_cnt == 3'(MEM_LAT)) begin
            cpu_ack  <= 1'b1;
            cpu_data <= mem_dout;
            state    <= IDLE;
          end else
            lat_cnt <= lat_cnt + 3'd1;
        DL_WR: begin
          if (buf_addr < 25'(ROM_SIZE)) begin
            mem_we     <= 1'b1;
            mem_addr   <= buf_addr[15:0];
            mem_din    <= buf_data;
            mem_region <= region;
          end
          dl_wait <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dl_rom_arbiter.sv
// tb_dl_rom_arbiter: vector table, directed corner sequences and randomized traffic
// checked against a transaction-level model of the arbiter.
module tb_dl_rom_arbiter;
  localparam int MEM_LAT = 2;
  localparam int HOLD    = 16;
  logic        clk_sys = 0, RESET_N = 0, ioctl_download = 0, ioctl_wr = 0, cpu_req = 0;
  logic [24:0] ioctl_addr = 0;
  logic [7:0]  ioctl_dout = 0;
  logic [15:0] cpu_addr = 0;
  logic [7:0]  mem_dout;
  logic        dl_wait, dl_overrun, cpu_ack, mem_we, core_reset;
  logic [7:0]  cpu_data, mem_din;
  logic [15:0] mem_addr;
  logic [1:0]  mem_region;
  int passed = 0, total = 0;

  typedef struct {logic [24:0] a; logic [7:0] d; int we; logic [1:0] r;} vec_t;
  typedef struct packed {logic [15:0] a; logic [7:0] d; logic [1:0] r;} wr_t;
  vec_t vt[10];
  wr_t  exp_q[$], got_q[$];

  dl_rom_arbiter #(.MEM_LAT(MEM_LAT), .HOLD_CYC(HOLD)) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dl_wait(dl_wait), .dl_overrun(dl_overrun),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_region(mem_region),
    .mem_dout(mem_dout), .core_reset(core_reset));

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;
  endfunction
  assign mem_dout = ram_byte(mem_addr);

  function automatic logic [1:0] region_of(input int a);
    return a < 'hC000 ? 2'd0 : a < 'hE000 ? 2'd1 : a < 'hF000 ? 2'd2 : 2'd3;
  endfunction

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick_mon;
    tick;
    if (mem_we) got_q.push_back('{mem_addr, mem_din, mem_region});
  endtask

  task automatic do_reset;
    RESET_N = 0;
    tick;
    tick;
    RESET_N = 1;
  endtask

  task automatic count_hold(output int n);
    n = 0;
    while (core_reset && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output int waits,
                           output int wes, output logic [15:0] wa, output logic [7:0] wd,
                           output logic [1:0] wr_reg);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1;
    waits = 0; wes = 0; wa = 0; wd = 0; wr_reg = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      ioctl_wr = 0;
      if (dl_wait) waits++;
      if (mem_we) begin
        wes++; wa = mem_addr; wd = mem_din; wr_reg = mem_region;
      end
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, output int lat, output logic [7:0] data);
    cpu_addr = a; cpu_req = 1; lat = 0;
    do begin
      tick;
      lat++;
    end while (!cpu_ack && lat < 20);
    data = cpu_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, waits, wes, gap, lat, ack_t, we_t, acks, lows;
    logic [15:0] wa, ca;
    logic [7:0] wd, rd, rdat;
    logic [1:0] wr_reg, wreg;
    logic [24:0] ra;
    vt[0] = '{25'h0005, 8'hA5, 1, 2'd0};
    vt[1] = '{25'hC010, 8'hA5, 1, 2'd1};
    vt[2] = '{25'hE001, 8'hA5, 1, 2'd2};
    vt[3] = '{25'hF0FF, 8'hA5, 1, 2'd3};
    vt[4] = '{25'h10002, 8'hA5, 0, 2'd0};
    vt[5] = '{25'hBFFF, 8'h3C, 1, 2'd0};
    vt[6] = '{25'hDFFF, 8'h4D, 1, 2'd1};
    vt[7] = '{25'hEFFF, 8'h5E, 1, 2'd2};
    vt[8] = '{25'hFFFF, 8'h6F, 1, 2'd3};
    vt[9] = '{25'h1FFFFFF, 8'h70, 0, 2'd0};

    do_reset;
    check("rst_core_reset", core_reset, 1);
    check("rst_dl_wait", dl_wait, 0);
    check("rst_overrun", dl_overrun, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_data", cpu_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_region", mem_region, 0);
    count_hold(n);
    check("rst_hold_cycles", n, HOLD);

    ioctl_download = 1;
    for (int i = 0; i < 10; i++) begin
      send_byte(vt[i].a, vt[i].d, waits, wes, wa, wd, wr_reg);
      check($sformatf("vec%0d_dl_wait_cycles", i), waits, 2);
      check($sformatf("vec%0d_we_count", i), wes, vt[i].we);
      check($sformatf("vec%0d_core_reset", i), core_reset, 1);
      if (vt[i].we != 0) begin
        check($sformatf("vec%0d_mem_addr", i), wa, vt[i].a[15:0]);
        check($sformatf("vec%0d_mem_din", i), wd, vt[i].d);
        check($sformatf("vec%0d_region", i), wr_reg, vt[i].r);
      end
    end
    check("no_overrun_after_table", dl_overrun, 0);

    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(3, 5);
      ra = ($urandom_range(0, 7) == 0) ? 25'h10000 + 25'($urandom_range(0, 'hFFFF))
                                       : 25'($urandom_range(0, 'hFFFF));
      rd = 8'($urandom);
      if (ra < 25'h10000) exp_q.push_back('{ra[15:0], rd, region_of(int'(ra))});
      ioctl_addr = ra; ioctl_dout = rd; ioctl_wr = 1;
      tick_mon;
      ioctl_wr = 0;
      for (int g = 1; g < gap; g++) tick_mon;
    end
    for (int g = 0; g < 6; g++) tick_mon;
    check("rand_write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) check($sformatf("rand_write%0d", i), got_q[i], exp_q[i]);
    check("rand_no_overrun", dl_overrun, 0);

    ioctl_addr = 25'h0100; ioctl_dout = 8'h11; ioctl_wr = 1;
    tick;
    ioctl_addr = 25'h0200; ioctl_dout = 8'h22;
    tick;
    ioctl_wr = 0;
    wes = 0; wa = 0; wd = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (mem_we) begin wes++; wa = mem_addr; wd = mem_din; end
    end
    check("ovr_we_count", wes, 1);
    check("ovr_kept_addr", wa, 16'h0100);
    check("ovr_kept_data", wd, 8'h11);
    check("ovr_flag", dl_overrun, 1);
    send_byte(25'h0300, 8'h33, waits, wes, wa, wd, wr_reg);
    check("ovr_after_write", wes, 1);
    check("ovr_sticky", dl_overrun, 1);

    ioctl_download = 0;
    do_reset;
    check("ovr_cleared_by_reset", dl_overrun, 0);
    check("rst2_core_reset", core_reset, 1);

    cpu_read(16'h1234, lat, rdat);
    check("cpu_lat", lat - 1, MEM_LAT + 1);
    check("cpu_data", rdat, 8'h5A);
    cpu_read(16'h1234, lat, rdat);
    check("cpu_b2b_lat", lat - 1, MEM_LAT + 1);
    cpu_req = 0;
    tick;
    check("cpu_ack_one_cycle", cpu_ack, 0);
    check("cpu_data_held", cpu_data, 8'h5A);

    for (int i = 0; i < 20; i++) begin
      ca = 16'($urandom);
      cpu_read(ca, lat, rdat);
      check($sformatf("rcpu%0d_lat", i), lat - 1, MEM_LAT + 1);
      check($sformatf("rcpu%0d_data", i), rdat, ram_byte(ca));
      cpu_req = 0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick;
    end
    for (int g = 0; g < 4; g++) tick;

    cpu_addr = 16'h2000; cpu_req = 1;
    tick;
    ioctl_download = 1; ioctl_addr = 25'hC020; ioctl_dout = 8'h77; ioctl_wr = 1;
    ack_t = 0; we_t = 0; acks = 0; lows = 0; rdat = 0; wa = 0; wd = 0; wreg = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      ioctl_wr = 0;
      if (!core_reset) lows++;
      if (cpu_ack) begin acks++; ack_t = i; rdat = cpu_data; end
      if (mem_we) begin we_t = i; wa = mem_addr; wd = mem_din; wreg = mem_region; end
    end
    check("mix_ack_time", ack_t, 3);
    check("mix_ack_count", acks, 1);
    check("mix_read_data", rdat, ram_byte(16'h2000));
    check("mix_write_time", we_t, 5);
    check("mix_write_addr", wa, 16'hC020);
    check("mix_write_data", wd, 8'h77);
    check("mix_write_region", wreg, 1);
    check("mix_core_reset_low_cycles", lows, 0);
    cpu_req = 0;
    ioctl_download = 0;
    count_hold(n);
    check("dl_hold_cycles", n, HOLD);

    ioctl_download = 1;
    tick;
    ioctl_download = 0;
    for (int i = 0; i < 5; i++) tick;
    ioctl_download = 1;
    tick;
    ioctl_download = 0;
    check("rehold_core_reset", core_reset, 1);
    count_hold(n);
    check("rehold_cycles", n, HOLD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
